seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_display_scan.sv | 152 +++++++++++++++
 tb/tb_seg_display_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan
// Eight-digit multiplexed hex display driver for a common-anode,
// active-low 7-segment module. A 32-bit shadow register captures data_in
// whenever enable is high. A free-running divider steps the digit index
// every SCAN_DIV cycles. Anode, segment and decimal-point outputs are
// registered, so they show the digit index and shadow value of the
// previous cycle.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant non-zero nibble are
//   blanked (an=8'hFF, seg=7'h7F). Digit 0 is never blanked. Scan timing
//   is identical with and without the macro.

module seg_display_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        enable,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // Divider width covers 0..SCAN_DIV-1. The minimum of 1 bit keeps the
    // declaration legal for the smallest divisor.
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Blank pattern: every anode off, every segment off.
    localparam logic [7:0] AN_BLANK  = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment codes, bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Hex nibble to active-low segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

    logic [31:0]      shadow;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit;
    logic             div_wrap;
    logic [3:0]       cur_nibble;
    logic             cur_blank;

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign cur_nibble = shadow[{digit, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] top_digit;

    // Find the most significant non-zero nibble; zero shadow leaves digit 0.
    always_comb begin
        top_digit = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (shadow[4*i +: 4] != 4'h0) begin
                top_digit = 3'(i);
            end
        end
    end

    assign cur_blank = (digit > top_digit);
`else
    assign cur_blank = 1'b0;
`endif

    // Shadow capture: reset wins over enable, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= 32'h0;
        end else if (enable) begin
            shadow <= data_in;
        end
    end

    // Dwell divider: counts 0..SCAN_DIV-1 and wraps, independent of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Digit index advances on each divider wrap; 3-bit rollover gives 7->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= 3'd0;
        end else if (div_wrap) begin
            digit <= digit + 3'd1;
        end
    end

    // Registered drive: one cycle behind the digit index and shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_BLANK;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            dp <= 1'b1;
            if (cur_blank) begin
                an  <= AN_BLANK;
                seg <= SEG_BLANK;
            end else begin
                an  <= ~(8'd1 << digit);
                seg <= hex_to_seg(cur_nibble);
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
// Directed bench for seg_display_scan with SCAN_DIV=4. Inputs are driven
// 1 time unit after each rising edge; outputs are sampled at that same
// point, so each check sees the result of the edge just taken.
// Build with +define+LEADING_ZERO_BLANK_EN to exercise the blanking variant.

module tb_seg_display_scan;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dataIn;
    logic        enable;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checkCount = 0;
    int passCount  = 0;

    // Hand-written segment table {g..a}, active-low.
    logic [6:0] segTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [31:0] walkVal = 32'h89ABCDEF;

    seg_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (dataIn),
        .enable  (enable),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive all inputs in one place.
    task automatic applyStimulus(input logic r, input logic en, input logic [31:0] d);
        rst    = r;
        enable = en;
        dataIn = d;
    endtask

    // Expected anode pattern for a lit digit.
    function automatic logic [7:0] anFor(input int k);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << k);
    endfunction

    // Compare an, seg and dp against expected values.
    task automatic checkOutput(input string tag, input logic [7:0] expAn, input logic [6:0] expSeg);
        checkCount++;
        assert (an === expAn) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s.an observed=%h expected=%h", tag, an, expAn);
        end
        checkCount++;
        assert (seg === expSeg) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s.seg observed=%h expected=%h", tag, seg, expSeg);
        end
        checkCount++;
        assert (dp === 1'b1) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s.dp observed=%b expected=1", tag, dp);
        end
    endtask

    // Reset for two edges; the last reset edge is the timing reference.
    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset with enable high and junk data: the junk must be discarded.
        applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF);
        tick(3);
        $display("[TB] reset state");
        checkOutput("reset", 8'hFF, 7'h7F);

        // Release: digit 0 of zero shadow, then digit 1 four cycles later.
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("release_d0", 8'hFE, 7'h40);
        tick(3);
        checkOutput("dwell_d0", 8'hFE, 7'h40);
        tick(1);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("release_d1", 8'hFF, 7'h7F);
`else
        checkOutput("release_d1", 8'hFD, 7'h40);
`endif

        // Capture 0x12 and scan all slots.
        $display("[TB] leading zero pattern");
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h00000012);
        tick(1);
        checkOutput("cap12_first", 8'hFE, 7'h40);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("cap12_d0", 8'hFE, 7'h24);
        tick(4);
        checkOutput("cap12_d1", 8'hFD, 7'h79);
        for (int k = 2; k < 8; k++) begin
            tick(4);
`ifdef LEADING_ZERO_BLANK_EN
            checkOutput($sformatf("cap12_d%0d", k), 8'hFF, 7'h7F);
`else
            checkOutput($sformatf("cap12_d%0d", k), anFor(k), 7'h40);
`endif
        end
        tick(4);
        checkOutput("cap12_wrap", 8'hFE, 7'h24);

        // Enable held high: display follows data every cycle.
        $display("[TB] continuous tracking");
        applyStimulus(1'b0, 1'b1, 32'h00000033);
        tick(1);
        applyStimulus(1'b0, 1'b1, 32'h00000055);
        tick(1);
        checkOutput("track_33", 8'hFE, 7'h30);
        applyStimulus(1'b0, 1'b1, 32'h00000077);
        tick(1);
        checkOutput("track_55_d1", 8'hFD, 7'h12);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("track_77_d1", 8'hFD, 7'h78);

        // Full walk of 0x89ABCDEF.
        $display("[TB] full scan walk");
        doReset();
        applyStimulus(1'b0, 1'b1, walkVal);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("walk_d%0d", k), anFor(k), segTab[walkVal[4*k +: 4]]);
            tick(4);
        end

        // Enable low with data toggling: display holds the captured value.
        $display("[TB] hold with enable low");
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("hold_d%0d", k), anFor(k), segTab[walkVal[4*k +: 4]]);
            for (int j = 0; j < 4; j++) begin
                applyStimulus(1'b0, 1'b0, (j % 2 == 0) ? 32'hFFFFFFFF : 32'h0);
                tick(1);
            end
        end

        // Move to the slot where the digit register holds 5 and reset there.
        $display("[TB] mid-scan reset");
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(18);
        checkOutput("pre_rst_d4", 8'hEF, 7'h03);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick(1);
        checkOutput("mid_rst", 8'hFF, 7'h7F);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("mid_rel_d0", 8'hFE, 7'h40);
        tick(4);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("mid_rel_d1", 8'hFF, 7'h7F);
`else
        checkOutput("mid_rel_d1", 8'hFD, 7'h40);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
